// File: rtl/poly_pkg.sv
// Shared types and helpers for the cyclic polynomial multiplier datapath.
// Coefficient slicing, ternary encodings and the streamer state enum.
package poly_pkg;

    localparam int COEF_W     = 11;
    localparam int POLY_MAX_C = 64;
    localparam int POLY_MAX_W = POLY_MAX_C * COEF_W;
    localparam int POLY_IX_W  = $clog2(POLY_MAX_W);

    localparam logic [1:0] TERN_ZERO = 2'b00;
    localparam logic [1:0] TERN_POS  = 2'b01;
    localparam logic [1:0] TERN_NEG  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM
    } state_t;

    // Coefficient k lives at bits [11k+10:11k] of a zero-extended bus.
    function automatic logic [COEF_W-1:0] coef_at(
        input logic [POLY_MAX_W-1:0] bus,
        input int unsigned           k
    );
        logic [POLY_IX_W-1:0] base;
        base = POLY_IX_W'(k * COEF_W);
        return bus[base +: COEF_W];
    endfunction

endpackage

// File: rtl/poly_mod3_lift.sv
// Centre-lift a mod-2^W coefficient and reduce it mod 3 to a ternary code.
// Only instantiated when POLY_MOD3_LIFT_EN is defined.
module poly_mod3_lift
    import poly_pkg::*;
#(
    parameter int W = COEF_W
) (
    input  logic [W-1:0] coef,
    output logic [1:0]   tern
);

    // Lifting subtracts 2^W; 2^W mod 3 is 2 for odd W, 1 for even W.
    localparam logic [2:0] ADJ = (W % 2 == 1) ? 3'd1 : 3'd2;

    logic [1:0] r_raw;
    logic [2:0] r_sum;
    logic [1:0] r;

    always_comb begin
        r_raw = 2'(coef % W'(3));
        r_sum = {1'b0, r_raw};
        if (coef[W-1]) begin
            r_sum = {1'b0, r_raw} + ADJ;
        end
        r = (r_sum >= 3'd3) ? 2'(r_sum - 3'd3) : r_sum[1:0];
        case (r)
            2'd1:    tern = TERN_POS;
            2'd2:    tern = TERN_NEG;
            default: tern = TERN_ZERO;
        endcase
    end

endmodule

// File: rtl/poly_coeff_streamer.sv
// Snapshots the multiplier product bus and streams one coefficient per beat.
// Define POLY_MOD3_LIFT_EN to emit centre-lifted mod-3 ternary codes instead.
module poly_coeff_streamer
    import poly_pkg::*;
#(
    parameter int N = 5,
    parameter int W = COEF_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [(N+1)*W-1:0]     poly_i,
    input  logic                   capture_i,
    output logic [W-1:0]           coeff_o,
    output logic [$clog2(N+1):0]   idx_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   last_o,
    output logic                   busy_o,
    output logic                   overrun_o
);

    localparam int IW = $clog2(N+1) + 1;
    localparam int PW = (N+1) * W;
    localparam logic [IW-1:0] LAST_IX = IW'(N);

    state_t state_q, state_n;

    logic [PW-1:0]         snap_q, snap_n;
    logic [POLY_MAX_W-1:0] snap_ext;
    logic [W-1:0]          coeff_n;
    logic [IW-1:0]         idx_n, idx_inc, sel_idx;
    logic                  valid_n, last_n, busy_n, ovr_n;
    logic                  hs;
    logic [W-1:0]          sel_word, out_word;

    assign snap_ext = POLY_MAX_W'(snap_q);
    assign idx_inc  = idx_o + 1'b1;
    assign sel_idx  = (state_q == LOAD) ? '0 : idx_inc;
    assign sel_word = W'(coef_at(snap_ext, 32'(sel_idx)));

`ifdef POLY_MOD3_LIFT_EN
    logic [1:0] tern;

    poly_mod3_lift #(.W(W)) u_lift (
        .coef (sel_word),
        .tern (tern)
    );

    assign out_word = {{(W-2){1'b0}}, tern};
`else
    assign out_word = sel_word;
`endif

    always_comb begin
        state_n = state_q;
        snap_n  = snap_q;
        coeff_n = coeff_o;
        idx_n   = idx_o;
        valid_n = valid_o;
        last_n  = last_o;
        busy_n  = busy_o;
        // The final-handshake cycle still counts as busy.
        ovr_n   = overrun_o | (capture_i & busy_o);
        hs      = valid_o & ready_i;

        case (state_q)
            IDLE: begin
                if (capture_i) begin
                    snap_n  = poly_i;
                    busy_n  = 1'b1;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                coeff_n = out_word;
                idx_n   = '0;
                valid_n = 1'b1;
                last_n  = (LAST_IX == '0);
                state_n = STREAM;
            end
            STREAM: begin
                if (hs) begin
                    if (last_o) begin
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        coeff_n = out_word;
                        idx_n   = idx_inc;
                        last_n  = (idx_inc == LAST_IX);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            coeff_o   <= '0;
            idx_o     <= '0;
            valid_o   <= 1'b0;
            last_o    <= 1'b0;
            busy_o    <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            state_q   <= state_n;
            snap_q    <= snap_n;
            coeff_o   <= coeff_n;
            idx_o     <= idx_n;
            valid_o   <= valid_n;
            last_o    <= last_n;
            busy_o    <= busy_n;
            overrun_o <= ovr_n;
        end
    end

endmodule

// File: tb/tb_poly_coeff_streamer.sv
// Scoreboard bench for poly_coeff_streamer: stimulus queues expected beats,
// a negedge monitor pops and compares on every handshake.
module tb_poly_coeff_streamer;

    localparam int N  = 5;
    localparam int W  = 11;
    localparam int IW = $clog2(N+1) + 1;

    typedef int cv_t [6];

    typedef struct packed {
        logic [W-1:0]  c;
        logic [IW-1:0] i;
        logic          l;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [(N+1)*W-1:0]   poly_i = '0;
    logic                 capture_i = 1'b0;
    logic [W-1:0]         coeff_o;
    logic [IW-1:0]        idx_o;
    logic                 valid_o;
    logic                 ready_i = 1'b0;
    logic                 last_o;
    logic                 busy_o;
    logic                 overrun_o;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total    = 0;
    int   hs_cnt   = 0;
    logic hold_v   = 1'b0;
    exp_t held;

    always #5 clk = ~clk;

    poly_coeff_streamer #(.N(N), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .poly_i    (poly_i),
        .capture_i (capture_i),
        .coeff_o   (coeff_o),
        .idx_o     (idx_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .last_o    (last_o),
        .busy_o    (busy_o),
        .overrun_o (overrun_o)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [W-1:0] expv(input int v);
`ifdef POLY_MOD3_LIFT_EN
        int s;
        int r;
        s = (v >= 1024) ? v - 2048 : v;
        r = ((s % 3) + 3) % 3;
        return (r == 0) ? 11'd0 : (r == 1) ? 11'd1 : 11'd3;
`else
        return W'(v);
`endif
    endfunction

    function automatic logic [(N+1)*W-1:0] pack(input cv_t v);
        logic [(N+1)*W-1:0] p;
        p = '0;
        for (int k = 0; k <= N; k++) p[k*W +: W] = W'(v[k]);
        return p;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", 32'(valid_o), 32'd1);
                chk("hold_data", 32'({coeff_o, idx_o, last_o}), 32'(held));
            end
            hold_v = 1'b0;
            if (valid_o && ready_i) begin
                exp_t e;
                hs_cnt++;
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_beat: got idx %0d expected none",
                             idx_o);
                end else begin
                    e = sb.pop_front();
                    chk("coeff", 32'(coeff_o), 32'(e.c));
                    chk("idx", 32'(idx_o), 32'(e.i));
                    chk("last", 32'(last_o), 32'(e.l));
                end
            end else if (valid_o) begin
                hold_v = 1'b1;
                held   = '{c: coeff_o, i: idx_o, l: last_o};
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start(input cv_t v, input int nexp);
        for (int k = 0; k < nexp; k++)
            sb.push_back('{c: expv(v[k]), i: IW'(k), l: (k == N)});
        poly_i    = pack(v);
        capture_i = 1'b1;
        cyc(1);
        capture_i = 1'b0;
    endtask

    task automatic wait_idx(input int target);
        int n = 0;
        while (!(valid_o && idx_o == IW'(target)) && n < 50) begin
            cyc(1);
            n++;
        end
        chk("wait_idx", 32'(valid_o && idx_o == IW'(target)), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 100) begin
            cyc(1);
            n++;
        end
        chk("wait_idle", 32'(busy_o), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        chk("reset_outs",
            32'({coeff_o, idx_o, valid_o, last_o, busy_o, overrun_o}), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        cv_t v1, v2, va, vb, vc, vd, vm;
        bit  pat [4];
        v1  = '{1, 2, 3, 4, 5, 2047};
        v2  = '{100, 0, 2047, 1024, 1023, 7};
        va  = '{11, 22, 33, 44, 55, 66};
        vb  = '{5, 4, 3, 2, 1, 0};
        vc  = '{9, 8, 7, 6, 5, 4};
        vd  = '{600, 601, 602, 603, 604, 605};
        vm  = '{0, 1, 2, 2047, 1024, 1023};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        do_reset();

        // basic stream, ready held high
        ready_i = 1'b1;
        cyc(2);
        chk("idle_ready_no_valid", 32'(valid_o), 32'd0);
        start(v1, 6);
        chk("load_busy", 32'(busy_o), 32'd1);
        chk("load_no_valid", 32'(valid_o), 32'd0);
        cyc(1);
        chk("first_valid", 32'({valid_o, idx_o}), 32'({1'b1, IW'(0)}));
        cyc(5);
        chk("last_at_n", 32'({last_o, idx_o}), 32'({1'b1, IW'(N)}));
        cyc(1);
        chk("end_outs", 32'({valid_o, last_o, busy_o}), 32'd0);
        chk("no_overrun", 32'(overrun_o), 32'd0);

        // backpressure
        ready_i = 1'b0;
        hs_cnt  = 0;
        start(v2, 6);
        for (int k = 0; k < 80 && busy_o; k++) begin
            ready_i = pat[k % 4];
            cyc(1);
        end
        chk("bp_done", 32'(busy_o), 32'd0);
        chk("bp_handshakes", 32'(hs_cnt), 32'd6);
        ready_i = 1'b1;

        // capture while busy is dropped and sticks overrun
        start(va, 6);
        wait_idx(2);
        poly_i    = pack(vb);
        capture_i = 1'b1;
        cyc(1);
        capture_i = 1'b0;
        chk("overrun_set", 32'(overrun_o), 32'd1);
        wait_idle();
        start(vb, 6);
        wait_idle();
        chk("overrun_sticky", 32'(overrun_o), 32'd1);

        // reset mid-stream at idx 3
        do_reset();
        start(vc, 3);
        wait_idx(3);
        ready_i = 1'b0;
        reset   = 1'b1;
        cyc(1);
        chk("midrst_outs",
            32'({coeff_o, idx_o, valid_o, last_o, busy_o, overrun_o}), 32'd0);
        chk("midrst_sb", 32'(sb.size()), 32'd0);
        reset   = 1'b0;
        ready_i = 1'b1;
        start(vc, 6);
        wait_idle();

        // capture coinciding with last handshake
        start(vd, 6);
        wait_idx(5);
        poly_i    = pack(v1);
        capture_i = 1'b1;
        cyc(1);
        capture_i = 1'b0;
        chk("lastcap_overrun", 32'(overrun_o), 32'd1);
        chk("lastcap_idle", 32'({valid_o, last_o, busy_o}), 32'd0);
        cyc(3);
        chk("lastcap_dropped", 32'({valid_o, busy_o}), 32'd0);

        // edge values (raw, or ternary when lifting is built in)
        start(vm, 6);
        wait_idle();

        cyc(2);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
